// File: rtl/b2xx_reset_pkg.sv
// Shared types and width helpers for the B2xx clock-ready / reset sequencer.
package b2xx_reset_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLDOFF   = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } seq_state_t;

    localparam int SYNC_STAGES = 2;

    // Bits needed to hold 0..max_val. Never returns less than one bit.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/b2xx_lock_filter.sv
// Lock-input synchronisers, masking and consecutive-low filter.
// o_loss pulses for one cycle after the LOCK_FILTER-th consecutive low sample.
module b2xx_lock_filter
    import b2xx_reset_pkg::*;
#(
    parameter int NUM_LOCKS   = 2,
    parameter int LOCK_FILTER = 4
) (
    input  logic                 bus_clk,
    input  logic                 reset_global,
    input  logic [NUM_LOCKS-1:0] i_locked_in,
    input  logic [NUM_LOCKS-1:0] i_lock_mask,
    output logic                 o_all_locked,
    output logic                 o_loss
);

    localparam int            FW        = cnt_width(LOCK_FILTER);
    localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILTER - 1);
    localparam logic [FW-1:0] FILT_MAX  = FW'(LOCK_FILTER);
    localparam logic [FW-1:0] FILT_ONE  = FW'(1);

    logic [NUM_LOCKS-1:0] r_sync [SYNC_STAGES];
    logic [FW-1:0]        r_low_cnt;
    logic                 r_loss;
    logic                 w_all_locked;

    // Two-flop synchroniser per lock input
    always_ff @(posedge bus_clk or posedge reset_global) begin
        if (reset_global) begin
            r_sync[0] <= {NUM_LOCKS{1'b0}};
            r_sync[1] <= {NUM_LOCKS{1'b0}};
        end else begin
            r_sync[0] <= i_locked_in;
            r_sync[1] <= r_sync[0];
        end
    end

    assign w_all_locked = &(r_sync[1] | ~i_lock_mask);

    // Count consecutive lows; saturate so a long outage reports a single loss
    always_ff @(posedge bus_clk or posedge reset_global) begin
        if (reset_global) begin
            r_low_cnt <= {FW{1'b0}};
            r_loss    <= 1'b0;
        end else if (w_all_locked) begin
            r_low_cnt <= {FW{1'b0}};
            r_loss    <= 1'b0;
        end else begin
            if (r_low_cnt != FILT_MAX) begin
                r_low_cnt <= r_low_cnt + FILT_ONE;
            end
            r_loss <= (r_low_cnt == FILT_LAST);
        end
    end

    assign o_all_locked = w_all_locked;
    assign o_loss       = r_loss;

endmodule

// File: rtl/b2xx_reset_sequencer.sv
// Waits for qualified PLL/MMCM lock, holds off, then releases the domain resets in
// ascending order; a filtered lock loss or soft reset re-asserts them all and restarts.
module b2xx_reset_sequencer
    import b2xx_reset_pkg::*;
#(
    parameter int NUM_LOCKS      = 2,
    parameter int NUM_DOMAINS    = 3,
    parameter int HOLDOFF_CYCLES = 65536,
    parameter int GAP_CYCLES     = 16,
    parameter int LOCK_FILTER    = 4,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                   bus_clk,
    input  logic                   reset_global,
    input  logic [NUM_LOCKS-1:0]   i_locked_in,
    input  logic [NUM_LOCKS-1:0]   i_lock_mask,
    input  logic                   i_soft_reset,
    input  logic                   i_clear_status,
    output logic [NUM_DOMAINS-1:0] o_rst_out,
    output logic                   o_clocks_ready,
    output logic [1:0]             o_state,
    output logic                   o_lock_lost,
    output logic [CNT_WIDTH-1:0]   o_relock_count
);

    localparam int            HW        = cnt_width(HOLDOFF_CYCLES);
    localparam int            GW        = cnt_width(GAP_CYCLES);
    localparam int            DW        = cnt_width(NUM_DOMAINS - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
    localparam logic [GW-1:0] GAP_ONE   = GW'(1);
    localparam logic [DW-1:0] DOM_LAST  = DW'(NUM_DOMAINS - 1);
    localparam logic [DW-1:0] DOM_ONE   = DW'(1);
    localparam logic [CNT_WIDTH-1:0] RC_ONE = CNT_WIDTH'(1);

    seq_state_t             r_state;
    seq_state_t             w_state_nxt;
    logic [HW-1:0]          r_hold_cnt,  w_hold_cnt_nxt;
    logic [GW-1:0]          r_gap_cnt,   w_gap_cnt_nxt;
    logic [DW-1:0]          r_dom_idx,   w_dom_idx_nxt;
    logic [NUM_DOMAINS-1:0] r_rst_out,   w_rst_nxt;
    logic                   r_clocks_ready;
    logic                   r_lock_lost;
    logic [CNT_WIDTH-1:0]   r_relock_count;

    logic w_all_locked;
    logic w_loss;
    logic w_loss_event;
    logic w_restart;

    b2xx_lock_filter #(
        .NUM_LOCKS   (NUM_LOCKS),
        .LOCK_FILTER (LOCK_FILTER)
    ) u_lock_filter (
        .bus_clk      (bus_clk),
        .reset_global (reset_global),
        .i_locked_in  (i_locked_in),
        .i_lock_mask  (i_lock_mask),
        .o_all_locked (w_all_locked),
        .o_loss       (w_loss)
    );

    // A filtered loss only counts once the sequence has started releasing;
    // before that the raw lock check in HOLDOFF already handles dropouts.
    assign w_loss_event = w_loss & ((r_state == RELEASE) | (r_state == RUN));
    assign w_restart    = i_soft_reset | w_loss_event;

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt    = r_state;
        w_hold_cnt_nxt = r_hold_cnt;
        w_gap_cnt_nxt  = r_gap_cnt;
        w_dom_idx_nxt  = r_dom_idx;
        w_rst_nxt      = r_rst_out;
        if (w_restart) begin
            w_state_nxt    = WAIT_LOCK;
            w_hold_cnt_nxt = {HW{1'b0}};
            w_gap_cnt_nxt  = {GW{1'b0}};
            w_dom_idx_nxt  = {DW{1'b0}};
            w_rst_nxt      = {NUM_DOMAINS{1'b1}};
        end else begin
            case (r_state)
                WAIT_LOCK: begin
                    w_rst_nxt      = {NUM_DOMAINS{1'b1}};
                    w_hold_cnt_nxt = {HW{1'b0}};
                    if (w_all_locked) begin
                        w_state_nxt = HOLDOFF;
                    end else begin
                        w_state_nxt = WAIT_LOCK;
                    end
                end
                HOLDOFF: begin
                    if (!w_all_locked) begin
                        w_state_nxt    = WAIT_LOCK;
                        w_hold_cnt_nxt = {HW{1'b0}};
                    end else if (r_hold_cnt == HOLD_LAST) begin
                        w_rst_nxt[0]  = 1'b0;
                        w_gap_cnt_nxt = {GW{1'b0}};
                        w_dom_idx_nxt = DOM_ONE;
                        if (NUM_DOMAINS == 1) begin
                            w_state_nxt = RUN;
                        end else begin
                            w_state_nxt = RELEASE;
                        end
                    end else begin
                        w_hold_cnt_nxt = r_hold_cnt + HOLD_ONE;
                    end
                end
                RELEASE: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        w_rst_nxt[r_dom_idx] = 1'b0;
                        w_gap_cnt_nxt        = {GW{1'b0}};
                        if (r_dom_idx == DOM_LAST) begin
                            w_state_nxt = RUN;
                        end else begin
                            w_dom_idx_nxt = r_dom_idx + DOM_ONE;
                        end
                    end else begin
                        w_gap_cnt_nxt = r_gap_cnt + GAP_ONE;
                    end
                end
                RUN: begin
                    w_rst_nxt   = {NUM_DOMAINS{1'b0}};
                    w_state_nxt = RUN;
                end
                default: begin
                    w_state_nxt = WAIT_LOCK;
                    w_rst_nxt   = {NUM_DOMAINS{1'b1}};
                end
            endcase
        end
    end

    // Sequencer state and registered reset outputs
    always_ff @(posedge bus_clk or posedge reset_global) begin
        if (reset_global) begin
            r_state        <= WAIT_LOCK;
            r_hold_cnt     <= {HW{1'b0}};
            r_gap_cnt      <= {GW{1'b0}};
            r_dom_idx      <= {DW{1'b0}};
            r_rst_out      <= {NUM_DOMAINS{1'b1}};
            r_clocks_ready <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_hold_cnt     <= w_hold_cnt_nxt;
            r_gap_cnt      <= w_gap_cnt_nxt;
            r_dom_idx      <= w_dom_idx_nxt;
            r_rst_out      <= w_rst_nxt;
            r_clocks_ready <= (w_state_nxt == RUN);
        end
    end

    // Loss bookkeeping: a set beats a simultaneous clear; the count saturates
    always_ff @(posedge bus_clk or posedge reset_global) begin
        if (reset_global) begin
            r_lock_lost    <= 1'b0;
            r_relock_count <= {CNT_WIDTH{1'b0}};
        end else begin
            if (w_loss_event) begin
                r_lock_lost <= 1'b1;
            end else if (i_clear_status) begin
                r_lock_lost <= 1'b0;
            end
            if (w_loss_event && (r_relock_count != {CNT_WIDTH{1'b1}})) begin
                r_relock_count <= r_relock_count + RC_ONE;
            end
        end
    end

    assign o_rst_out      = r_rst_out;
    assign o_clocks_ready = r_clocks_ready;
    assign o_state        = r_state;
    assign o_lock_lost    = r_lock_lost;
    assign o_relock_count = r_relock_count;

endmodule

// File: tb/tb_b2xx_reset_sequencer.sv
// Scoreboard bench: stimulus queues expected output changes with their cycle; a monitor
// compares every observed change of the output vector against the queue head.
module tb_b2xx_reset_sequencer;

    localparam int NL   = 2;
    localparam int ND   = 3;
    localparam int HOLD = 8;
    localparam int GAP  = 4;
    localparam int FILT = 4;
    localparam int CW   = 2;

    logic          bus_clk = 1'b0;
    logic          reset_global;
    logic [NL-1:0] locked_in;
    logic [NL-1:0] lock_mask;
    logic          soft_reset;
    logic          clear_status;
    logic [ND-1:0] rst_out;
    logic          clocks_ready;
    logic [1:0]    state;
    logic          lock_lost;
    logic [CW-1:0] relock_count;

    b2xx_reset_sequencer #(
        .NUM_LOCKS      (NL),
        .NUM_DOMAINS    (ND),
        .HOLDOFF_CYCLES (HOLD),
        .GAP_CYCLES     (GAP),
        .LOCK_FILTER    (FILT),
        .CNT_WIDTH      (CW)
    ) dut (
        .bus_clk        (bus_clk),
        .reset_global   (reset_global),
        .i_locked_in    (locked_in),
        .i_lock_mask    (lock_mask),
        .i_soft_reset   (soft_reset),
        .i_clear_status (clear_status),
        .o_rst_out      (rst_out),
        .o_clocks_ready (clocks_ready),
        .o_state        (state),
        .o_lock_lost    (lock_lost),
        .o_relock_count (relock_count)
    );

    always #5 bus_clk = ~bus_clk;

    int cyc = 0;
    always @(posedge bus_clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [8:0] vec;
        bit         chk_cyc;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic       exp_ll;
    logic [1:0] exp_rc;

    function automatic logic [8:0] pack(logic [2:0] r, logic cr, logic [1:0] st,
                                        logic ll, logic [1:0] rc);
        return {r, cr, st, ll, rc};
    endfunction

    task automatic expect_at(int c, logic [2:0] r, logic cr, logic [1:0] st);
        exp_t e;
        e.cyc     = c;
        e.vec     = pack(r, cr, st, exp_ll, exp_rc);
        e.chk_cyc = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge bus_clk);
            #2;
        end
    endtask

    // Full sequence from the edge that enters HOLDOFF
    task automatic push_sequence(int t0);
        expect_at(t0,                3'b111, 1'b0, 2'd1);
        expect_at(t0 + HOLD,         3'b110, 1'b0, 2'd2);
        expect_at(t0 + HOLD + GAP,   3'b100, 1'b0, 2'd2);
        expect_at(t0 + HOLD + 2*GAP, 3'b000, 1'b1, 2'd3);
    endtask

    task automatic do_soft();
        int s;
        s = cyc;
        expect_at(s + 1, 3'b111, 1'b0, 2'd0);
        push_sequence(s + 2);
        soft_reset = 1'b1;
        step(1);
        soft_reset = 1'b0;
        step(20);
    endtask

    // Four-cycle dropout on lock 1 from RUN; optional clear_status on the loss edge
    task automatic do_loss(bit clr);
        int d;
        d      = cyc;
        exp_ll = 1'b1;
        exp_rc = (exp_rc == 2'd3) ? 2'd3 : exp_rc + 2'd1;
        expect_at(d + 7, 3'b111, 1'b0, 2'd0);
        push_sequence(d + 8);
        locked_in[1] = 1'b0;
        step(4);
        locked_in[1] = 1'b1;
        step(2);
        if (clr) clear_status = 1'b1;
        step(1);
        clear_status = 1'b0;
        step(22);
    endtask

    logic [8:0] mon_prev;
    logic [8:0] mon_cur;
    bit         mon_first = 1'b1;
    exp_t       mon_e;

    always @(negedge bus_clk) begin
        mon_cur = {rst_out, clocks_ready, state, lock_lost, relock_count};
        if (mon_first || (mon_cur !== mon_prev)) begin
            mon_first = 1'b0;
            mon_prev  = mon_cur;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL output_event cyc=%0d got=%b required=no change", cyc, mon_cur);
            end else begin
                mon_e = exp_q.pop_front();
                if ((mon_cur !== mon_e.vec) || (mon_e.chk_cyc && (cyc != mon_e.cyc))) begin
                    n_fail++;
                    $display("FAIL output_event got=%b at cyc %0d required=%b at cyc %0d",
                             mon_cur, cyc, mon_e.vec, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        exp_t e0;
        int   s;
        reset_global = 1'b1;
        locked_in    = 2'b00;
        lock_mask    = 2'b11;
        soft_reset   = 1'b0;
        clear_status = 1'b0;
        exp_ll       = 1'b0;
        exp_rc       = 2'd0;
        e0.cyc       = 0;
        e0.vec       = pack(3'b111, 1'b0, 2'd0, 1'b0, 2'd0);
        e0.chk_cyc   = 1'b0;
        exp_q.push_back(e0);

        // Bring-up: lock seen through 2 sync flops, T0 three edges after the drive
        step(3);
        reset_global = 1'b0;
        step(2);
        push_sequence(cyc + 3);
        locked_in = 2'b11;
        step(25);

        // Three low samples stay below the filter
        locked_in[1] = 1'b0;
        step(3);
        locked_in[1] = 1'b1;
        step(10);

        do_loss(1'b0);
        do_soft();

        // One-cycle dropout in HOLDOFF at count 5 restarts the hold-off
        s = cyc;
        expect_at(s + 1, 3'b111, 1'b0, 2'd0);
        expect_at(s + 2, 3'b111, 1'b0, 2'd1);
        expect_at(s + 8, 3'b111, 1'b0, 2'd0);
        push_sequence(s + 9);
        soft_reset = 1'b1;
        step(1);
        soft_reset = 1'b0;
        step(4);
        locked_in[0] = 1'b0;
        step(1);
        locked_in[0] = 1'b1;
        step(25);

        // Masked lock input is ignored entirely
        lock_mask = 2'b01;
        locked_in = 2'b01;
        step(5);
        do_soft();
        locked_in[1] = 1'b1;
        step(3);
        locked_in[1] = 1'b0;
        step(8);
        locked_in = 2'b11;
        step(4);
        lock_mask = 2'b11;
        step(5);

        // Plain clear, then clear coincident with a loss
        exp_ll = 1'b0;
        expect_at(cyc + 1, 3'b000, 1'b1, 2'd3);
        clear_status = 1'b1;
        step(1);
        clear_status = 1'b0;
        step(3);
        do_loss(1'b1);
        do_loss(1'b0);
        do_loss(1'b0);
        do_loss(1'b0);

        // Asynchronous reset mid-RELEASE, asserted between edges
        s = cyc;
        expect_at(s + 1,  3'b111, 1'b0, 2'd0);
        expect_at(s + 2,  3'b111, 1'b0, 2'd1);
        expect_at(s + 10, 3'b110, 1'b0, 2'd2);
        soft_reset = 1'b1;
        step(1);
        soft_reset = 1'b0;
        step(11);
        exp_ll = 1'b0;
        exp_rc = 2'd0;
        expect_at(cyc, 3'b111, 1'b0, 2'd0);
        reset_global = 1'b1;
        step(4);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drained got=%0d pending required=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/b2xx_reset_sequencer.md
Name: b2xx_reset_sequencer

Overview:
Parametrised clock-ready and reset sequencer for the B2xx top level. It monitors NUM_LOCKS PLL/MMCM lock inputs and applies a programmable hold-off. It then releases NUM_DOMAINS active-high resets one after another in ascending index order. On a filtered lock loss or a soft reset it re-asserts every reset and re-sequences. All outputs are in the bus_clk domain; downstream reset_sync instances carry each reset into its destination clock domain.

Parameters:
NUM_LOCKS, 2, number of lock inputs monitored (>=1)
NUM_DOMAINS, 3, number of sequenced reset outputs (>=1)
HOLDOFF_CYCLES, 65536, bus_clk cycles spent in HOLDOFF before the first release (>=1)
GAP_CYCLES, 16, bus_clk cycles between consecutive domain releases (>=1)
LOCK_FILTER, 4, consecutive low samples of all_locked needed to declare a loss (>=1)
CNT_WIDTH, 8, width of relock_count

Ports:
bus_clk  in  1  clock; 100 MHz
reset_global  in  1  asynchronous, active-high reset
locked_in  in  NUM_LOCKS  asynchronous lock indicators
lock_mask  in  NUM_LOCKS  quasi-static; 1 = lock input monitored
soft_reset  in  1  synchronous one-cycle pulse; forces re-sequence
clear_status  in  1  synchronous pulse; clears lock_lost
rst_out  out  NUM_DOMAINS  active-high domain resets; index 0 released first
clocks_ready  out  1  high only in RUN
state  out  2  current FSM state, for readback
lock_lost  out  1  sticky flag: a filtered loss occurred while in RELEASE or RUN
relock_count  out  CNT_WIDTH  saturating count of filtered losses from RELEASE or RUN

Behaviour:
- Reset values while reset_global is high:
  - rst_out = all ones; clocks_ready = 0; state = WAIT_LOCK.
  - lock_lost = 0; relock_count = 0; all counters = 0; synchroniser flops = 0.
- Lock qualification:
  - Each locked_in bit passes through a 2-flop synchroniser (2-cycle latency).
  - all_locked = AND over (locked_sync | ~lock_mask). lock_mask = 0 forces all_locked = 1.
- Loss filter:
  - A counter increments on each consecutive all_locked = 0 sample and clears on any 1 sample.
  - loss fires on the edge that samples the LOCK_FILTER-th consecutive low.
- WAIT_LOCK: rst_out all ones. On the edge sampling all_locked = 1 (call it T0), go to HOLDOFF with the hold-off counter at 0.
- HOLDOFF:
  - Counter increments each cycle.
  - Any raw all_locked = 0 sample returns to WAIT_LOCK immediately. This is unfiltered and does not count as a loss.
  - At edge T0+HOLDOFF_CYCLES: go to RELEASE and deassert rst_out[0] on the same edge.
- RELEASE:
  - rst_out[k] deasserts at edge T0+HOLDOFF_CYCLES+k*GAP_CYCLES.
  - On the edge releasing rst_out[NUM_DOMAINS-1]: enter RUN and assert clocks_ready.
  - If NUM_DOMAINS = 1, RUN is entered at T0+HOLDOFF_CYCLES.
- RUN: holds until a filtered loss or a soft_reset.
- Loss in RELEASE or RUN:
  - On the next edge, all rst_out = 1, clocks_ready = 0, state = WAIT_LOCK.
  - lock_lost is set and relock_count increments, saturating at 2^CNT_WIDTH-1.
  - Released resets never re-deassert out of order.
- soft_reset (any state):
  - Same re-assert and WAIT_LOCK entry as a loss.
  - lock_lost and relock_count are not changed.
  - If it coincides with a loss, the loss bookkeeping still applies.
- clear_status clears lock_lost. If a set and a clear occur in the same cycle, the set wins.
- Reset ordering: assertion is simultaneous across all domains; deassertion is strictly ascending in index.
- rst_out is registered (glitch-free) so it can feed reset_sync directly.
- Asynchronous reset_global mid-sequence returns every output to its reset value immediately.

Decomposition:
- Package b2xx_reset_pkg:
  - State encoding: WAIT_LOCK = 2'd0, HOLDOFF = 2'd1, RELEASE = 2'd2, RUN = 2'd3.
  - Width helper constants for the hold-off counter ($clog2(HOLDOFF_CYCLES+1)) and the gap counter.
- Sub-module b2xx_lock_filter:
  - Contains the per-bit 2-flop synchronisers, the mask/AND, and the consecutive-low counter.
  - Outputs all_locked and a one-cycle loss pulse.
- The FSM, domain index, and gap counter stay in the top of this block.

Test Plan:
1. HOLDOFF_CYCLES=8, GAP=4, NUM_DOMAINS=3, both locks high after reset_global falls -> rst_out[0] low at T0+8, rst_out[1] low at T0+12, rst_out[2] low and clocks_ready high at T0+16; state=3.
2. In RUN, drop locked_in[1] for 3 cycles (LOCK_FILTER=4) -> no change. Then drop it for 4 cycles -> rst_out=3'b111 on the edge after the 4th low sample; lock_lost=1; relock_count=1.
3. During HOLDOFF at count 5, single-cycle low on locked_in[0] -> state returns to WAIT_LOCK, relock_count unchanged. When lock is restored, the hold-off restarts from 0 and the full 8 cycles elapse.
4. lock_mask=2'b01, locked_in[1] held low -> sequence completes normally. A later loss on locked_in[1] has no effect.
5. soft_reset pulse in RUN -> all resets asserted next edge; re-sequence completes after 16 cycles; relock_count and lock_lost unchanged. clear_status coincident with a loss -> lock_lost stays 1.
6. CNT_WIDTH=2, five forced losses -> relock_count saturates at 3. Assert reset_global mid-RELEASE -> rst_out=3'b111 and clocks_ready=0 asynchronously.
